// File: rtl/ram_regfile_param.sv
// Parametrised multi-port register-file RAM: byte-lane masked writes, per-lane valid bits,
// registered reads with selectable write-first forwarding.
module ram_regfile_param #(
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned LANE   = 8,
   parameter int unsigned NUM_R  = 8,
   parameter int unsigned NUM_W  = 4,
   parameter int unsigned BYPASS = 1,
   localparam int unsigned NLANES = WIDTH / LANE,
   localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_R-1:0]          R_en,
   input  logic [NUM_R*AW-1:0]       R_addr,
   output logic [NUM_R*WIDTH-1:0]    R_data,
   output logic [NUM_R-1:0]          R_valid,
   input  logic [NUM_W-1:0]          W_en,
   input  logic [NUM_W*AW-1:0]       W_addr,
   input  logic [NUM_W*WIDTH-1:0]    W_data,
   input  logic [NUM_W*NLANES-1:0]   W_mask
);

   logic [WIDTH-1:0]       r_mem    [DEPTH];
   logic [NLANES-1:0]      r_lvalid [DEPTH];
   logic [NUM_R*WIDTH-1:0] r_rdata;
   logic [NUM_R-1:0]       r_rvalid;

   logic [AW-1:0]          w_waddr   [NUM_W];
   logic [NUM_W-1:0]       w_wr_ok;
   logic [AW-1:0]          w_raddr   [NUM_R];
   logic [NUM_R-1:0]       w_rd_ok;
   logic [WIDTH-1:0]       w_rd_next [NUM_R];

   // Address decode; out-of-range writes are dropped, out-of-range reads return zero.
   always_comb begin
      for (int unsigned j = 0; j < NUM_W; j++) begin
         w_waddr[j] = W_addr[j*AW +: AW];
         w_wr_ok[j] = W_en[j] && (32'(w_waddr[j]) < DEPTH);
      end
      for (int unsigned i = 0; i < NUM_R; i++) begin
         w_raddr[i] = R_addr[i*AW +: AW];
         w_rd_ok[i] = 32'(w_raddr[i]) < DEPTH;
      end
   end

   // Ascending port order: the highest-indexed writer of a lane takes effect.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int unsigned j = 0; j < NUM_W; j++) begin
            for (int unsigned l = 0; l < NLANES; l++) begin
               if (w_wr_ok[j] && W_mask[j*NLANES + l]) begin
                  r_mem[w_waddr[j]][l*LANE +: LANE] <= W_data[j*WIDTH + l*LANE +: LANE];
               end
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned d = 0; d < DEPTH; d++) begin
            r_lvalid[d] <= '0;
         end
      end else begin
         for (int unsigned j = 0; j < NUM_W; j++) begin
            for (int unsigned l = 0; l < NLANES; l++) begin
               if (w_wr_ok[j] && W_mask[j*NLANES + l]) begin
                  r_lvalid[w_waddr[j]][l] <= 1'b1;
               end
            end
         end
      end
   end

   // Next read value per port: stored lane if valid, overridden by the winning writer
   // of that lane when write-first forwarding is enabled.
   always_comb begin
      for (int unsigned i = 0; i < NUM_R; i++) begin
         w_rd_next[i] = '0;
         if (w_rd_ok[i]) begin
            for (int unsigned l = 0; l < NLANES; l++) begin
               if (r_lvalid[w_raddr[i]][l]) begin
                  w_rd_next[i][l*LANE +: LANE] = r_mem[w_raddr[i]][l*LANE +: LANE];
               end
               if (BYPASS != 0) begin
                  for (int unsigned j = 0; j < NUM_W; j++) begin
                     if (w_wr_ok[j] && W_mask[j*NLANES + l] && (w_waddr[j] == w_raddr[i])) begin
                        w_rd_next[i][l*LANE +: LANE] = W_data[j*WIDTH + l*LANE +: LANE];
                     end
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rdata  <= '0;
         r_rvalid <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_R; i++) begin
            r_rvalid[i] <= R_en[i];
            if (R_en[i]) begin
               r_rdata[i*WIDTH +: WIDTH] <= w_rd_next[i];
            end
         end
      end
   end

   assign R_data  = r_rdata;
   assign R_valid = r_rvalid;

endmodule

// File: tb/tb_ram_regfile_param.sv
// Bench for ram_regfile_param: directed table, corner sequences and random traffic checked
// against an entry/lane array model (write-first reads post-edge state, read-first pre-edge).
module tb_ram_regfile_param;

   localparam int DEPTH = 32;
   localparam int WIDTH = 64;
   localparam int NR    = 8;
   localparam int NW    = 4;
   localparam int NL    = 8;
   localparam int AW    = 5;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic [NR-1:0]       R_en;
   logic [NR*AW-1:0]    R_addr;
   logic [NW-1:0]       W_en;
   logic [NW*AW-1:0]    W_addr;
   logic [NW*WIDTH-1:0] W_data;
   logic [NW*NL-1:0]    W_mask;
   logic [NR*WIDTH-1:0] rd_wf, rd_rf;
   logic [NR-1:0]       rv_wf, rv_rf;

   // Small configuration: DEPTH=20, WIDTH=32, LANE=16, NUM_R=2, NUM_W=1
   logic [1:0]  s_ren;
   logic [9:0]  s_raddr;
   logic [63:0] s_rdata;
   logic [1:0]  s_rvalid;
   logic [0:0]  s_wen;
   logic [4:0]  s_waddr;
   logic [31:0] s_wdata;
   logic [1:0]  s_wmask;

   ram_regfile_param dut_wf (
      .clock(clock), .reset(reset),
      .R_en(R_en), .R_addr(R_addr), .R_data(rd_wf), .R_valid(rv_wf),
      .W_en(W_en), .W_addr(W_addr), .W_data(W_data), .W_mask(W_mask)
   );

   ram_regfile_param #(.BYPASS(0)) dut_rf (
      .clock(clock), .reset(reset),
      .R_en(R_en), .R_addr(R_addr), .R_data(rd_rf), .R_valid(rv_rf),
      .W_en(W_en), .W_addr(W_addr), .W_data(W_data), .W_mask(W_mask)
   );

   ram_regfile_param #(.DEPTH(20), .WIDTH(32), .LANE(16), .NUM_R(2), .NUM_W(1)) dut_small (
      .clock(clock), .reset(reset),
      .R_en(s_ren), .R_addr(s_raddr), .R_data(s_rdata), .R_valid(s_rvalid),
      .W_en(s_wen), .W_addr(s_waddr), .W_data(s_wdata), .W_mask(s_wmask)
   );

   logic [63:0]   m_data [DEPTH];
   logic [7:0]    m_val  [DEPTH];
   logic [63:0]   e_wf   [NR];
   logic [63:0]   e_rf   [NR];
   logic [NR-1:0] e_v;
   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [63:0] model_rd(input int a);
      logic [63:0] m;
      for (int l = 0; l < NL; l++) m[l*8 +: 8] = {8{m_val[a][l]}};
      return m_data[a] & m;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      R_en = '0; R_addr = '0; W_en = '0; W_addr = '0; W_data = '0; W_mask = '0;
      s_ren = '0; s_raddr = '0; s_wen = '0; s_waddr = '0; s_wdata = '0; s_wmask = '0;
   endtask

   task automatic set_wr(input int j, input int a, input logic [63:0] d, input logic [7:0] m);
      W_en[j] = 1'b1;
      W_addr[j*AW +: AW] = AW'(a);
      W_data[j*WIDTH +: WIDTH] = d;
      W_mask[j*NL +: NL] = m;
   endtask

   task automatic set_rd(input int i, input int a);
      R_en[i] = 1'b1;
      R_addr[i*AW +: AW] = AW'(a);
   endtask

   // One clock edge: update the model from the applied inputs, then compare every port.
   task automatic step();
      logic [63:0] pre [NR];
      int a;
      for (int i = 0; i < NR; i++) pre[i] = model_rd(int'(R_addr[i*AW +: AW]));
      if (reset) begin
         for (int d = 0; d < DEPTH; d++) m_val[d] = '0;
         for (int i = 0; i < NR; i++) begin
            e_wf[i] = '0;
            e_rf[i] = '0;
         end
         e_v = '0;
      end else begin
         for (int j = 0; j < NW; j++) begin
            if (W_en[j]) begin
               a = int'(W_addr[j*AW +: AW]);
               for (int l = 0; l < NL; l++) begin
                  if (W_mask[j*NL + l]) begin
                     m_data[a][l*8 +: 8] = W_data[j*WIDTH + l*8 +: 8];
                     m_val[a][l] = 1'b1;
                  end
               end
            end
         end
         for (int i = 0; i < NR; i++) begin
            e_v[i] = R_en[i];
            if (R_en[i]) begin
               e_rf[i] = pre[i];
               e_wf[i] = model_rd(int'(R_addr[i*AW +: AW]));
            end
         end
      end
      @(posedge clock);
      #1;
      for (int i = 0; i < NR; i++) begin
         check($sformatf("wf_data[%0d]", i), rd_wf[i*WIDTH +: WIDTH], e_wf[i]);
         check($sformatf("rf_data[%0d]", i), rd_rf[i*WIDTH +: WIDTH], e_rf[i]);
         check($sformatf("wf_valid[%0d]", i), {63'b0, rv_wf[i]}, {63'b0, e_v[i]});
         check($sformatf("rf_valid[%0d]", i), {63'b0, rv_rf[i]}, {63'b0, e_v[i]});
      end
   endtask

   typedef struct {
      logic        w_en;
      int          w_port;
      int          w_addr;
      logic [63:0] w_data;
      logic [7:0]  w_mask;
      logic        r_en;
      int          r_port;
      int          r_addr;
      logic        chk;
      logic [63:0] exp_wf;
      logic [63:0] exp_rf;
   } vec_t;

   vec_t tbl [8];

   initial begin
      tbl[0] = '{1'b1, 0, 5, 64'h1122334455667788, 8'h0F, 1'b0, 0, 0, 1'b0, 64'h0, 64'h0};
      tbl[1] = '{1'b0, 0, 0, 64'h0, 8'h00, 1'b0, 0, 0, 1'b0, 64'h0, 64'h0};
      tbl[2] = '{1'b0, 0, 0, 64'h0, 8'h00, 1'b1, 3, 5, 1'b1,
                 64'h0000000055667788, 64'h0000000055667788};
      tbl[3] = '{1'b1, 1, 2, 64'h1, 8'hFF, 1'b0, 0, 0, 1'b0, 64'h0, 64'h0};
      tbl[4] = '{1'b1, 2, 2, 64'hFFFFFFFFFFFFFFFF, 8'h01, 1'b1, 0, 2, 1'b1,
                 64'h00000000000000FF, 64'h0000000000000001};
      tbl[5] = '{1'b0, 0, 0, 64'h0, 8'h00, 1'b1, 0, 2, 1'b1, 64'hFF, 64'hFF};
      tbl[6] = '{1'b0, 0, 0, 64'h0, 8'h00, 1'b1, 6, 31, 1'b1, 64'h0, 64'h0};
      tbl[7] = '{1'b1, 3, 5, 64'hCAFEBABE00000000, 8'hF0, 1'b1, 7, 5, 1'b1,
                 64'hCAFEBABE55667788, 64'h0000000055667788};

      for (int d = 0; d < DEPTH; d++) begin
         m_data[d] = '0;
         m_val[d]  = '0;
      end
      clear_inputs();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;

      // Every address on every port reads zero after reset
      for (int a = 0; a < DEPTH; a++) begin
         clear_inputs();
         for (int i = 0; i < NR; i++) set_rd(i, (a + i) % DEPTH);
         step();
      end
      clear_inputs();
      step();

      // Small configuration: out-of-range write dropped, in-range round trip, forwarding
      clear_inputs();
      s_wen = 1'b1; s_waddr = 5'd25; s_wdata = 32'h12345678; s_wmask = 2'b11;
      step();
      clear_inputs();
      s_ren[0] = 1'b1; s_raddr[4:0] = 5'd25;
      step();
      check("small_oor_data", {32'b0, s_rdata[31:0]}, 64'h0);
      check("small_oor_valid", {62'b0, s_rvalid}, 64'h1);
      clear_inputs();
      s_wen = 1'b1; s_waddr = 5'd19; s_wdata = 32'hA5A55A5A; s_wmask = 2'b11;
      step();
      clear_inputs();
      s_ren = 2'b11; s_raddr[4:0] = 5'd5; s_raddr[9:5] = 5'd19;
      step();
      check("small_rt_data", {32'b0, s_rdata[63:32]}, 64'hA5A55A5A);
      check("small_alias_data", {32'b0, s_rdata[31:0]}, 64'h0);
      check("small_rt_valid", {62'b0, s_rvalid}, 64'h3);
      clear_inputs();
      s_wen = 1'b1; s_waddr = 5'd19; s_wdata = 32'h00001234; s_wmask = 2'b01;
      s_ren[0] = 1'b1; s_raddr[4:0] = 5'd19;
      step();
      check("small_fwd_data", {32'b0, s_rdata[31:0]}, 64'hA5A51234);
      clear_inputs();
      step();
      check("small_idle_valid", {62'b0, s_rvalid}, 64'h0);

      // Directed table
      foreach (tbl[k]) begin
         clear_inputs();
         if (tbl[k].w_en) set_wr(tbl[k].w_port, tbl[k].w_addr, tbl[k].w_data, tbl[k].w_mask);
         if (tbl[k].r_en) set_rd(tbl[k].r_port, tbl[k].r_addr);
         step();
         if (tbl[k].chk) begin
            check($sformatf("tbl%0d_wf", k), rd_wf[tbl[k].r_port*WIDTH +: WIDTH], tbl[k].exp_wf);
            check($sformatf("tbl%0d_rf", k), rd_rf[tbl[k].r_port*WIDTH +: WIDTH], tbl[k].exp_rf);
         end
      end

      // Write conflict: highest port wins; disjoint lanes both commit
      clear_inputs();
      set_wr(0, 9, 64'h1234123412341234, 8'h00);
      set_wr(1, 9, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
      set_wr(3, 9, 64'hBBBBBBBBBBBBBBBB, 8'hFF);
      step();
      clear_inputs();
      set_wr(0, 10, 64'h1111111111111111, 8'h0F);
      set_wr(1, 10, 64'h2222222222222222, 8'hF0);
      set_rd(1, 9);
      step();
      check("conflict_wf", rd_wf[1*WIDTH +: WIDTH], 64'hBBBBBBBBBBBBBBBB);
      check("conflict_rf", rd_rf[1*WIDTH +: WIDTH], 64'hBBBBBBBBBBBBBBBB);
      clear_inputs();
      set_rd(2, 10);
      step();
      check("split_lanes", rd_wf[2*WIDTH +: WIDTH], 64'h2222222211111111);

      // Idle hold, then reset coinciding with a write
      clear_inputs();
      set_wr(0, 12, 64'hDEAD, 8'hFF);
      step();
      clear_inputs();
      set_rd(4, 12);
      step();
      check("hold_first", rd_wf[4*WIDTH +: WIDTH], 64'hDEAD);
      for (int c = 0; c < 3; c++) begin
         clear_inputs();
         step();
         check($sformatf("hold_data%0d", c), rd_wf[4*WIDTH +: WIDTH], 64'hDEAD);
         check($sformatf("hold_valid%0d", c), {63'b0, rv_wf[4]}, 64'h0);
      end
      clear_inputs();
      set_wr(0, 7, 64'h7777777777777777, 8'hFF);
      reset = 1'b1;
      step();
      reset = 1'b0;
      clear_inputs();
      set_rd(0, 7);
      set_rd(1, 12);
      step();
      check("rst_write_dropped", rd_wf[0 +: WIDTH], 64'h0);
      check("rst_valid_cleared", rd_wf[1*WIDTH +: WIDTH], 64'h0);
      check("rst_port4_zero", rd_wf[4*WIDTH +: WIDTH], 64'h0);

      // Random traffic concentrated on a few addresses to provoke conflicts and forwarding
      for (int c = 0; c < 400; c++) begin
         clear_inputs();
         reset = ($urandom_range(0, 59) == 0);
         for (int j = 0; j < NW; j++) begin
            if ($urandom_range(0, 1) == 1) begin
               set_wr(j, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                                     : int'($urandom_range(0, 5)),
                      {$urandom, $urandom}, 8'($urandom));
            end
         end
         for (int i = 0; i < NR; i++) begin
            if ($urandom_range(0, 2) != 0) begin
               set_rd(i, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                                     : int'($urandom_range(0, 5)));
            end
         end
         step();
      end
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_regfile_param.md
Name: ram_regfile_param

Overview:
- Parametrised multi-port register-file RAM for the mock-ALU register file.
- Successor of the fixed 32x64 8-read/4-write byte-masked array, on a single clock with synchronous reset.
- Adds:
  - configurable depth, width, lane size and port counts;
  - defined write-write priority;
  - selectable read-first/write-first forwarding;
  - per-lane valid tracking, so unwritten data reads as zero instead of X;
  - registered read data that holds while idle.

Parameters:
- DEPTH, 32: number of entries (need not be a power of 2).
- WIDTH, 64: entry width in bits. Must be a multiple of LANE.
- LANE, 8: write-mask granularity in bits. NLANES = WIDTH/LANE.
- NUM_R, 8: number of read ports.
- NUM_W, 4: number of write ports.
- BYPASS, 1: 1 = write-first (same-edge writes forwarded to reads); 0 = read-first.
- Derived localparam AW = max(1, $clog2(DEPTH)).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- R_en  in  NUM_R  read enable, one bit per read port.
- R_addr  in  NUM_R*AW  read addresses; port i at [i*AW +: AW].
- R_data  out  NUM_R*WIDTH  registered read data; port i at [i*WIDTH +: WIDTH].
- R_valid  out  NUM_R  1-cycle pulse marking fresh R_data for port i.
- W_en  in  NUM_W  write enable, one bit per write port.
- W_addr  in  NUM_W*AW  write addresses.
- W_data  in  NUM_W*WIDTH  write data.
- W_mask  in  NUM_W*NLANES  lane mask; bit l covers data [l*LANE +: LANE].

Behaviour:
- Storage: DEPTH x WIDTH array, plus a lane-valid array of DEPTH x NLANES bits.
- Reset, while reset=1 at a rising edge:
  - all lane-valid bits cleared;
  - R_data = 0 and R_valid = 0 on all ports;
  - all writes and reads presented that cycle are ignored.
  - Array contents themselves are not cleared.
  - First edge with reset=0 operates normally.
- Write, at each edge with reset=0, for every write port j and lane l where W_en[j] & W_mask[j][l] & (W_addr[j] < DEPTH):
  - the lane is written with the corresponding W_data bits;
  - its lane-valid bit is set.
- Write conflicts: several ports writing the same address and lane on one edge → the highest port index wins. Non-overlapping lanes of the same address all commit.
- Out-of-range write address (≥ DEPTH): the write is dropped with no side effect.
- Read:
  - Latency is exactly 1 cycle.
  - If R_en[i]=1 at edge t, then after edge t: R_valid[i]=1, and R_data[i] holds the lane-wise result of the entry at R_addr[i].
  - Each lane reads its stored value if that lane is valid, else 0.
  - Out-of-range read address → all zeros, R_valid still 1.
- Idle read port: if R_en[i]=0 at edge t, R_valid[i]=0 after the edge and R_data[i] holds its previous value. Never X.
- Read/write same edge, same address:
  - BYPASS=1: each lane being written at edge t is forwarded, using the winning writer's data (valid treated as set). Other lanes read stored state.
  - BYPASS=0: R_data reflects state before edge t; the new data is visible from the next read.
- Read port independence: reads are independent; any number of ports may read the same address.
- Reads have no effect on the array.
- Timing: R_data is driven only by flops. No combinational path from any input to any output.

Test Plan:
- Reset check: assert reset 2 cycles, then read addresses 0..31 on all 8 ports → every R_data=0, and R_valid=1 exactly one cycle after each R_en.
- Masked write: W0 writes addr 5, data 0x1122334455667788, mask 0x0F; read port 3 reads addr 5 two cycles later → 0x0000000055667788.
- Write conflict: on one edge, W1 and W3 both write addr 9 mask 0xFF (data 0xAAAA.. and 0xBBBB..) and W0 writes addr 9 mask 0x00 → next read returns 0xBBBBBBBBBBBBBBBB.
- Forwarding, BYPASS=1: addr 2 holds 0x1; on the same edge W2 writes 0xFF..FF mask 0x01 and R0 reads addr 2 → R_data[0]=0x00000000000000FF. With BYPASS=0 the same stimulus gives 0x1.
- Idle hold, then reset mid-operation: R4 reads 0xDEAD, then R_en[4]=0 for 3 cycles → R_data[4] stays 0xDEAD with R_valid[4]=0. Then pulse reset on the same edge as a W0 write to addr 7 → addr 7 reads 0 afterwards and R_data[4]=0.
- Parametrisation: DEPTH=20, WIDTH=32, LANE=16, NUM_R=2, NUM_W=1. Write to addr 25 → dropped; read of addr 25 → 0 with R_valid=1. Write/read round-trip at addr 19 succeeds.
